// File: rtl/clock_enable_manager.sv
// Multi-channel reset sequencer and clock-enable divider on a single board clock.
// Channels leave reset in index order, then each strobes clk_en once per divisor period.
module clock_enable_manager #(
   parameter int NUM_CHANNELS      = 2,
   parameter int DIV_WIDTH         = 8,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int STAGGER_CYCLES    = 4
) (
   input  logic                              clk_ext,
   input  logic                              reset,
   input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] div,
   input  logic                              resync,
   output logic [NUM_CHANNELS-1:0]           clk_en,
   output logic [NUM_CHANNELS-1:0]           rstn_out,
   output logic                              ready
);

   localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
   localparam int STG_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
   localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [STG_W-1:0]     STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_STAGGER,
      ST_RUN
   } state_t;

   state_t                    state_q, state_d;
   logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;
   logic [STG_W-1:0]          stg_cnt_q, stg_cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NUM_CHANNELS-1:0]   rstn_q, rstn_d;
   logic                      ready_q, ready_d;

   logic [DIV_WIDTH-1:0]      cnt_q   [NUM_CHANNELS];
   logic [DIV_WIDTH-1:0]      cnt_d   [NUM_CHANNELS];
   logic [DIV_WIDTH-1:0]      div_l_q [NUM_CHANNELS];
   logic [DIV_WIDTH-1:0]      div_l_d [NUM_CHANNELS];
   logic [DIV_WIDTH-1:0]      div_eff [NUM_CHANNELS];
   logic                      resync_act;

   // Release sequencer: HOLD counts out the hold window, STAGGER walks idx_q over the channels.
   always_comb begin
      // NOTE: every _d gets a default up front so no branch can infer a latch.
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      stg_cnt_d  = stg_cnt_q;
      idx_d      = idx_q;
      rstn_d     = rstn_q;
      ready_d    = ready_q;
      case (state_q)
         ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               rstn_d[0] = 1'b1;
               if (NUM_CHANNELS == 1) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d   = ST_STAGGER;
                  idx_d     = IDX_W'(1);
                  stg_cnt_d = '0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_STAGGER: begin
            if (stg_cnt_q == STG_LAST) begin
               rstn_d[idx_q] = 1'b1;
               stg_cnt_d     = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               stg_cnt_d = stg_cnt_q + STG_W'(1);
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         div_eff[i] = (div[i*DIV_WIDTH +: DIV_WIDTH] == '0) ? DIV_ONE
                                                           : div[i*DIV_WIDTH +: DIV_WIDTH];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         clk_en[i] = rstn_q[i] && (cnt_q[i] == div_l_q[i] - DIV_ONE);
      end
   end

   // Resync is only honoured once every channel is out of reset.
   assign resync_act = ready_q && resync;

   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (!rstn_q[i] || resync_act || clk_en[i]) begin
            cnt_d[i]   = '0;
            div_l_d[i] = div_eff[i];
         end else begin
            cnt_d[i]   = cnt_q[i] + DIV_ONE;
            div_l_d[i] = div_l_q[i];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_ext) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         stg_cnt_q  <= '0;
         idx_q      <= '0;
         rstn_q     <= '0;
         ready_q    <= 1'b0;
         // NOTE: these per-channel arrays are plain flops, not RAM, so resetting them is fine.
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_q[i]   <= '0;
            div_l_q[i] <= DIV_ONE;
         end
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         stg_cnt_q  <= stg_cnt_d;
         idx_q      <= idx_d;
         rstn_q     <= rstn_d;
         ready_q    <= ready_d;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_q[i]   <= cnt_d[i];
            div_l_q[i] <= div_l_d[i];
         end
      end
   end

   assign rstn_out = rstn_q;
   assign ready    = ready_q;

endmodule
